// File: rtl/alu_exec_unit.sv
// Execute-stage ALU. Most ops finish in one cycle. MUL uses a shift-add
// loop that runs for WIDTH cycles. Input and output each use a
// valid/ready handshake, and the result register holds its value while
// the consumer stalls.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a new op when the output slot is free or draining
// S_MUL  | shift-add multiply in progress, cnt_q counts iterations
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             illegal_op
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_NOP = 3'b011;
  localparam logic [2:0] F_MUL = 3'b100;
  localparam logic [2:0] F_RSV = 3'b101;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready   = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero       = zero_q;
  assign busy       = (state_q == S_MUL);
  assign illegal_op = illegal_q;
  assign mul_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath result for the presented opcode.
  always_comb begin
    op_res = '0;
    case (alu_func)
      F_ADD:   op_res = a + b;
      F_SUB:   op_res = a - b;
      F_AND:   op_res = a & b;
      F_OR:    op_res = a | b;
      F_SLT:   op_res[0] = ($signed(a) < $signed(b));
      default: op_res = '0;
    endcase
  end

  // Next-state, multiply iteration and output register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    illegal_d   = accept && (alu_func == F_RSV);

    // A drained result is dropped unless a new completion replaces it below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (alu_func)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
              result_d    = op_res;
              zero_d      = (op_res == '0);
              out_valid_d = 1'b1;
            end
            F_MUL: begin
              state_d  = S_MUL;
              mcand_d  = a;
              mplier_d = b;
              acc_d    = '0;
              cnt_d    = '0;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          result_d    = mul_sum;
          zero_d      = (mul_sum == '0);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule
